// File: rtl/ex_div_if.sv
// Execute-stage to divider handshake: operands and control in, {remainder, quotient} and ready out.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// result {remainder, quotient} held while the execute stage keeps start_i high.
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  div_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBZ  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    // Operand magnitudes for the signed case
    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_abs, op2_abs;

    assign op1_neg = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
    assign op2_neg = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? (~div_if.opdata1_i + ONE) : div_if.opdata1_i;
    assign op2_abs = op2_neg ? (~div_if.opdata2_i + ONE) : div_if.opdata2_i;

    // One restoring step: the extra top bit of trial is the borrow that decides the quotient bit
    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_step, quo_step;
    logic [WIDTH-1:0]     rem_fix, quo_fix;
    logic                 unused_trial_bit;

    assign shifted          = {rem_q, dvd_q[WIDTH-1]};
    assign trial            = {1'b0, shifted} - {2'b00, dvs_q};
    assign q_bit            = ~trial[WIDTH+1];
    assign rem_step         = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step         = {dvd_q[WIDTH-2:0], q_bit};
    assign unused_trial_bit = trial[WIDTH];

    assign quo_fix = neg_quo_q ? (~quo_step + ONE) : quo_step;
    assign rem_fix = neg_rem_q ? (~rem_step + ONE) : rem_step;

    // NOTE: every next-state signal gets a hold default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (div_if.start_i && !div_if.annul_i) begin
                    if (div_if.opdata2_i == '0) begin
                        state_d = DBZ;
                    end else begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        rem_d     = '0;
                        dvd_d     = op1_abs;
                        dvs_d     = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end

            DBZ: begin
                if (!div_if.start_i || div_if.annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end

            RUN: begin
                if (!div_if.start_i || div_if.annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                if (!div_if.start_i || div_if.annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset clears the datapath too so
    // nothing from an aborted division can leak into a later result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign div_if.result_o = result_q;
    assign div_if.ready_o  = ready_q;

endmodule
